// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the IF/MEM memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } arb_state_e;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    // Byte-lane steering is built for exactly two 8-bit lanes.
    localparam int LANE_DATA_W = 16;

    function automatic bit data_w_ok(input int w);
        return w == LANE_DATA_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_steer.sv
// ============================================================================
// Module      : byte_lane_steer
// Description : Byte-enable and write-data replication for MEM-stage stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_steer
    import mem_port_arbiter_pkg::*;
(
    input  logic                   mem_byte,
    input  logic                   addr_lsb,
    input  logic [LANE_DATA_W-1:0] wdata,
    output logic [1:0]             be,
    output logic [LANE_DATA_W-1:0] steer_wdata
);

    always_comb begin
        be          = BE_WORD;
        steer_wdata = wdata;
        if (mem_byte) begin
            // Replicate the low byte so either lane carries it.
            be          = addr_lsb ? BE_HI : BE_LO;
            steer_wdata = {wdata[7:0], wdata[7:0]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-port memory between IF fetch and MEM load/store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_be,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    import mem_port_arbiter_pkg::*;

    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    if (!data_w_ok(DATA_W)) begin : g_data_w_check
        $error("mem_port_arbiter: DATA_W must be 16");
    end

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                drop_q, drop_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [1:0]          m_be_q, m_be_d;

    logic                if_pending;
    logic                mem_pending;
    logic                grant_mem;
    logic                grant_if;
    logic [1:0]          steer_be;
    logic [DATA_W-1:0]   steer_wdata;

    byte_lane_steer u_steer (
        .mem_byte    (mem_byte),
        .addr_lsb    (mem_addr[0]),
        .wdata       (mem_wdata),
        .be          (steer_be),
        .steer_wdata (steer_wdata)
    );

    // A requester whose done pulses this cycle is finished, not waiting.
    assign if_pending  = if_req  & ~if_done_q;
    assign mem_pending = mem_req & ~mem_done_q;

    assign grant_mem = (state_q == ST_IDLE) && mem_pending &&
                       ((streak_q < STREAK_MAX) || !if_pending);
    assign grant_if  = (state_q == ST_IDLE) && !grant_mem && if_pending && !if_flush;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_be_d      = m_be_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d   = ST_BUSY_MEM;
                    m_we_d    = mem_we;
                    m_addr_d  = mem_addr;
                    m_wdata_d = steer_wdata;
                    m_be_d    = mem_we ? steer_be : BE_WORD;
                end else if (grant_if) begin
                    state_d   = ST_BUSY_IF;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    m_be_d    = BE_WORD;
                end
            end
            ST_BUSY_IF: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (m_ack) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    // A flush seen at any point in the access discards its data.
                    if (!drop_q && !if_flush) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end
            end
            ST_BUSY_MEM: begin
                if (m_ack) begin
                    state_d    = ST_IDLE;
                    mem_done_d = 1'b1;
                    if (!m_we_q) begin
                        mem_rdata_d = m_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!if_req || grant_if) begin
            streak_d = '0;
        end else if (grant_mem && if_pending && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_be_q      <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_be_q      <= m_be_d;
        end
    end

    assign m_req     = (state_q != ST_IDLE);
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_be      = m_be_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    // Stalls depend only on requests and registered dones, never on m_ack.
    assign if_stall  = if_req  & ~if_done_q;
    assign mem_stall = mem_req & ~mem_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [1:0]  m_be;
    logic        m_ack;
    logic [15:0] m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_stall (mem_stall),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] st_addr  [3] = '{16'h0301, 16'h0300, 16'h0302};
    logic [15:0] st_wdata [3] = '{16'h00CD, 16'h00EF, 16'h4321};
    logic        st_byte  [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0]  st_be    [3] = '{2'b10, 2'b01, 2'b11};
    logic [15:0] st_mwd   [3] = '{16'hCDCD, 16'hEFEF, 16'h4321};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_cycles;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        m_ack     = 1'b0;
        m_rdata   = '0;

        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_eq("reset_m_req",   {31'd0, m_req}, 0);
        chk_eq("reset_outputs", {if_rdata, mem_rdata}, 0);
        chk_eq("reset_m_bus",   {m_we, m_be, m_addr, if_done, mem_done}, 0);

        // Fetch only, ack in second request cycle.
        stall_cycles = 0;
        if_req  = 1'b1;
        if_addr = 16'h0010;
        #1; if (if_stall) stall_cycles++;
        tick();
        chk_eq("fetch_m_req",  {31'd0, m_req}, 1);
        chk_eq("fetch_m_addr", {16'd0, m_addr}, 32'h0010);
        chk_eq("fetch_we_be",  {29'd0, m_we, m_be}, 32'h3);
        #1; if (if_stall) stall_cycles++;
        tick();
        m_ack   = 1'b1;
        m_rdata = 16'hA123;
        #1; if (if_stall) stall_cycles++;
        tick();
        m_ack = 1'b0;
        chk_eq("fetch_done",   {31'd0, if_done}, 1);
        chk_eq("fetch_rdata",  {16'd0, if_rdata}, 32'hA123);
        #1; if (if_stall) stall_cycles++;
        chk_eq("fetch_stall_cycles", stall_cycles, 3);
        if_req = 1'b0;
        tick();
        chk_eq("fetch_done_pulse", {31'd0, if_done}, 0);

        // Simultaneous requests: MEM first, then IF in MEM's done cycle.
        if_req   = 1'b1;
        if_addr  = 16'h0044;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 16'h0200;
        tick();
        chk_eq("simul_mem_first", {16'd0, m_addr}, 32'h0200);
        m_ack   = 1'b1;
        m_rdata = 16'h5A5A;
        tick();
        m_ack = 1'b0;
        chk_eq("simul_mem_done",  {31'd0, mem_done}, 1);
        chk_eq("simul_mem_rdata", {16'd0, mem_rdata}, 32'h5A5A);
        mem_req = 1'b0;
        tick();
        chk_eq("simul_if_grant",  {15'd0, m_req, m_addr}, 32'h1_0044);
        m_ack   = 1'b1;
        m_rdata = 16'h1234;
        tick();
        m_ack  = 1'b0;
        chk_eq("simul_if_done",   {30'd0, if_done, mem_done}, 32'h2);
        chk_eq("simul_if_rdata",  {16'd0, if_rdata}, 32'h1234);
        if_req = 1'b0;
        tick();

        // Stores: byte hi lane, byte lo lane, full word.
        for (int i = 0; i < 3; i++) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_byte  = st_byte[i];
            mem_addr  = st_addr[i];
            mem_wdata = st_wdata[i];
            tick();
            chk_eq($sformatf("store%0d_we_be", i), {29'd0, m_we, m_be}, {29'd0, 1'b1, st_be[i]});
            chk_eq($sformatf("store%0d_wdata", i), {16'd0, m_wdata}, {16'd0, st_mwd[i]});
            chk_eq($sformatf("store%0d_addr", i),  {16'd0, m_addr}, {16'd0, st_addr[i]});
            m_ack   = 1'b1;
            m_rdata = 16'hFFFF;
            tick();
            m_ack   = 1'b0;
            chk_eq($sformatf("store%0d_done", i),  {31'd0, mem_done}, 1);
            chk_eq($sformatf("store%0d_rdata", i), {16'd0, mem_rdata}, 32'h5A5A);
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            mem_byte = 1'b0;
            tick();
        end

        // Flush during BUSY_IF, then a redirected fetch proceeds.
        if_req  = 1'b1;
        if_addr = 16'h0080;
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        if_addr  = 16'h0090;
        m_ack    = 1'b1;
        m_rdata  = 16'hDEAD;
        tick();
        m_ack = 1'b0;
        chk_eq("flush_no_done", {31'd0, if_done}, 0);
        chk_eq("flush_rdata_kept", {16'd0, if_rdata}, 32'h1234);
        tick();
        chk_eq("flush_next_grant", {15'd0, m_req, m_addr}, 32'h1_0090);
        m_ack   = 1'b1;
        m_rdata = 16'hBEEF;
        tick();
        m_ack = 1'b0;
        chk_eq("flush_next_done", {15'd0, if_done, if_rdata}, 32'h1_BEEF);

        // Flush in the grant cycle blocks the grant; flush with ack drops.
        if_addr  = 16'h00A0;
        if_flush = 1'b1;
        tick();
        chk_eq("flush_blocks_grant", {31'd0, m_req}, 0);
        if_flush = 1'b0;
        tick();
        chk_eq("flush_late_grant", {31'd0, m_req}, 1);
        if_flush = 1'b1;
        m_ack    = 1'b1;
        m_rdata  = 16'h0BAD;
        tick();
        if_flush = 1'b0;
        m_ack    = 1'b0;
        if_req   = 1'b0;
        chk_eq("flush_with_ack", {15'd0, if_done, if_rdata}, 32'h0_BEEF);
        tick();

        // Starvation: flush held keeps IF out of MEM done cycles.
        if_req   = 1'b1;
        if_addr  = 16'h0100;
        if_flush = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 16'h0400;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk_eq($sformatf("starve_mem_grant%0d", g), {15'd0, m_req, m_addr}, 32'h1_0400);
            m_ack   = 1'b1;
            m_rdata = 16'(g);
            tick();
            m_ack = 1'b0;
            chk_eq($sformatf("starve_mem_done%0d", g), {31'd0, mem_done}, 1);
            tick();
        end
        tick();
        chk_eq("starve_mem_blocked", {31'd0, m_req}, 0);
        if_flush = 1'b0;
        tick();
        chk_eq("starve_if_grant", {15'd0, m_req, m_addr}, 32'h1_0100);
        m_ack   = 1'b1;
        m_rdata = 16'h7777;
        tick();
        m_ack  = 1'b0;
        if_req = 1'b0;
        chk_eq("starve_if_done", {15'd0, if_done, if_rdata}, 32'h1_7777);
        tick();
        chk_eq("starve_mem_resume", {15'd0, m_req, m_addr}, 32'h1_0400);
        m_ack   = 1'b1;
        m_rdata = 16'h2468;
        tick();
        m_ack   = 1'b0;
        mem_req = 1'b0;
        chk_eq("starve_mem_rdata", {15'd0, mem_done, mem_rdata}, 32'h1_2468);
        tick();

        // Reset during BUSY_MEM.
        mem_req  = 1'b1;
        mem_addr = 16'h0500;
        tick();
        chk_eq("rstmid_busy", {31'd0, m_req}, 1);
        rst = 1'b0;
        #1;
        chk_eq("rstmid_m_req_async", {31'd0, m_req}, 0);
        mem_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_eq("rstmid_outputs", {if_rdata, mem_rdata}, 0);
        chk_eq("rstmid_m_bus", {m_req, m_we, m_be, m_addr, if_done, mem_done}, 0);

        // A fresh fetch after reset with an immediate ack.
        if_req  = 1'b1;
        if_addr = 16'h0020;
        tick();
        m_ack   = 1'b1;
        m_rdata = 16'h1357;
        tick();
        m_ack  = 1'b0;
        if_req = 1'b0;
        chk_eq("post_reset_fetch", {15'd0, if_done, if_rdata}, 32'h1_1357);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
